// File: rtl/qspi_wr_fifo.sv
// QSPI slave write path: decodes WREN/WRDI/Page Program on di and packs data bytes into 16-bit FIFO words.
// Issues one SDRAM write request per WR_BL words, plus a short request for any words left pending at csn rise.
module qspi_wr_fifo #(
  parameter int unsigned WR_BL    = 2,
  parameter logic [7:0]  CMD_PP   = 8'h02,
  parameter logic [7:0]  CMD_WREN = 8'h06,
  parameter logic [7:0]  CMD_WRDI = 8'h04
) (
  input  logic        qspi_clk,
  input  logic        rst_n,
  input  logic        csn,
  input  logic        di,
  input  logic        wpn,
  input  logic        holdn,
  output logic [23:0] qspi_wr_addr,
  output logic [7:0]  qspi_wr_len,
  output logic        qspi_wr_req,
  output logic        wel,
  output logic        ovf,
  output logic        fifo_wen,
  output logic [15:0] fifo_wdata,
  input  logic        fifo_wfull
);

  typedef enum logic [1:0] {S_CMD, S_ADDR, S_DATA, S_IGNORE} state_t;

  localparam logic [23:0] BURST_BYTES = 24'(2 * WR_BL);
  localparam logic [7:0]  BURST_LAST  = 8'(WR_BL - 1);

  state_t      state, state_nxt;
  logic [4:0]  bit_cnt;
  logic [23:0] shift_q;
  logic [23:0] shift_in;
  logic [23:0] burst_addr;
  logic [23:0] req_addr_q;
  logic [7:0]  word_cnt;
  logic        burst_done_q;
  logic        cmd_done;
  logic        word_done;

  assign shift_in  = {shift_q[22:0], di};
  assign cmd_done  = (state == S_CMD)  && (bit_cnt == 5'd7);
  assign word_done = (state == S_DATA) && (bit_cnt == 5'd15);

  always_comb begin
    state_nxt = state;
    if (csn) begin
      state_nxt = S_CMD;
    end else if (holdn) begin
      case (state)
        S_CMD: begin
          if (cmd_done) begin
            if (shift_in[7:0] == CMD_PP && wel && wpn) state_nxt = S_ADDR;
            else                                       state_nxt = S_IGNORE;
          end
        end
        S_ADDR:  if (bit_cnt == 5'd23) state_nxt = S_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge qspi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_CMD;
      bit_cnt      <= '0;
      shift_q      <= '0;
      burst_addr   <= '0;
      req_addr_q   <= '0;
      word_cnt     <= '0;
      burst_done_q <= 1'b0;
      qspi_wr_addr <= '0;
      qspi_wr_len  <= '0;
      qspi_wr_req  <= 1'b0;
      wel          <= 1'b0;
      ovf          <= 1'b0;
      fifo_wen     <= 1'b0;
      fifo_wdata   <= '0;
    end else begin
      fifo_wen     <= 1'b0;
      qspi_wr_req  <= 1'b0;
      burst_done_q <= 1'b0;
      state        <= state_nxt;

      // Full-burst request trails the last word's fifo_wen slot by one cycle.
      if (burst_done_q) begin
        qspi_wr_req  <= 1'b1;
        qspi_wr_addr <= req_addr_q;
        qspi_wr_len  <= 8'(WR_BL);
      end

      if (csn) begin
        bit_cnt <= '0;
        if (state == S_DATA) begin
          wel <= 1'b0;
          if (word_cnt != 8'd0) begin
            qspi_wr_req  <= 1'b1;
            qspi_wr_addr <= burst_addr;
            qspi_wr_len  <= word_cnt;
            word_cnt     <= '0;
          end
        end
      end else if (holdn) begin
        shift_q <= shift_in;
        if (state_nxt != state || word_done) bit_cnt <= '0;
        else if (state != S_IGNORE)          bit_cnt <= bit_cnt + 5'd1;

        case (state)
          S_CMD: begin
            if (cmd_done) begin
              if (shift_in[7:0] == CMD_WREN)      wel <= 1'b1;
              else if (shift_in[7:0] == CMD_WRDI) wel <= 1'b0;
              else if (state_nxt == S_ADDR)       ovf <= 1'b0;
            end
          end
          S_ADDR: begin
            if (bit_cnt == 5'd23) begin
              burst_addr <= shift_in;
              word_cnt   <= '0;
            end
          end
          S_DATA: begin
            if (word_done) begin
              if (fifo_wfull) begin
                ovf <= 1'b1;
              end else begin
                fifo_wen   <= 1'b1;
                fifo_wdata <= shift_in[15:0];
              end
              // Dropped words still advance the burst and its address.
              if (word_cnt == BURST_LAST) begin
                word_cnt     <= '0;
                burst_done_q <= 1'b1;
                req_addr_q   <= burst_addr;
                burst_addr   <= burst_addr + BURST_BYTES;
              end else begin
                word_cnt <= word_cnt + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_wr_fifo.sv
// Bench for qspi_wr_fifo: transaction-level model schedules expected outputs per clock edge,
// one negedge process compares every cycle; directed cases also pin literal results.
module tb_qspi_wr_fifo;
  localparam int WR_BL = 2;

  logic        qspi_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csn = 1'b1;
  logic        di = 1'b0;
  logic        wpn = 1'b1;
  logic        holdn = 1'b1;
  logic        fifo_wfull = 1'b0;
  logic [23:0] qspi_wr_addr;
  logic [7:0]  qspi_wr_len;
  logic        qspi_wr_req;
  logic        wel;
  logic        ovf;
  logic        fifo_wen;
  logic [15:0] fifo_wdata;

  qspi_wr_fifo #(.WR_BL(WR_BL)) dut (
    .qspi_clk(qspi_clk), .rst_n(rst_n), .csn(csn), .di(di), .wpn(wpn), .holdn(holdn),
    .qspi_wr_addr(qspi_wr_addr), .qspi_wr_len(qspi_wr_len), .qspi_wr_req(qspi_wr_req),
    .wel(wel), .ovf(ovf), .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull)
  );

  always #5 qspi_clk = ~qspi_clk;

  int ecnt = 0;
  always @(posedge qspi_clk) ecnt <= ecnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected output events keyed by the clock edge after which they are visible.
  logic [16:0] wen_s[int];
  logic [31:0] req_s[int];
  logic        wel_s[int];
  logic        ovf_s[int];

  logic        m_wel = 1'b0, m_ovf = 1'b0;
  logic [23:0] m_addr = '0;
  logic [7:0]  m_len = '0;
  logic [15:0] wr_log[$];
  logic [31:0] req_log[$];

  logic        d_wel = 1'b0, d_ovf = 1'b0;
  logic [7:0]  tx_bytes[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %h, expected %h", nm, ecnt, act, exp);
    end
  endtask

  always @(negedge qspi_clk) begin
    int  k;
    logic ew, er;
    k = ecnt;
    if (!rst_n) begin
      m_wel = 1'b0; m_ovf = 1'b0; m_addr = '0; m_len = '0;
    end else begin
      if (wel_s.exists(k)) m_wel = wel_s[k];
      if (ovf_s.exists(k)) m_ovf = ovf_s[k];
      if (req_s.exists(k)) begin
        m_addr = req_s[k][23:0];
        m_len  = req_s[k][31:24];
      end
    end
    ew = wen_s.exists(k) && rst_n;
    er = req_s.exists(k) && rst_n;
    chk("fifo_wen", 32'(fifo_wen), 32'(ew));
    if (ew) chk("fifo_wdata", 32'(fifo_wdata), 32'(wen_s[k][15:0]));
    chk("qspi_wr_req", 32'(qspi_wr_req), 32'(er));
    chk("qspi_wr_addr", 32'(qspi_wr_addr), 32'(m_addr));
    chk("qspi_wr_len", 32'(qspi_wr_len), 32'(m_len));
    chk("wel", 32'(wel), 32'(m_wel));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (fifo_wen) wr_log.push_back(fifo_wdata);
    if (qspi_wr_req) req_log.push_back({qspi_wr_len, qspi_wr_addr});
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick(input logic c, input logic d, input logic h, input logic f, output int e);
    csn = c; di = d; holdn = h; fifo_wfull = f;
    e = ecnt + 1;
    @(negedge qspi_clk);
  endtask

  task automatic purge();
    int ks[$];
    foreach (wen_s[k]) if (k > ecnt) ks.push_back(k);
    foreach (ks[i]) wen_s.delete(ks[i]);
    ks.delete();
    foreach (req_s[k]) if (k > ecnt) ks.push_back(k);
    foreach (ks[i]) req_s.delete(ks[i]);
    ks.delete();
    foreach (wel_s[k]) if (k > ecnt) ks.push_back(k);
    foreach (ks[i]) wel_s.delete(ks[i]);
    ks.delete();
    foreach (ovf_s[k]) if (k > ecnt) ks.push_back(k);
    foreach (ks[i]) ovf_s.delete(ks[i]);
  endtask

  task automatic send_op(input logic [7:0] op, input logic wp, output logic acc);
    int e;
    wpn = wp;
    for (int i = 7; i >= 0; i--) tick(1'b0, op[i], 1'b1, rbit(), e);
    acc = 1'b0;
    if (op == 8'h06) begin d_wel = 1'b1; wel_s[e] = 1'b1; end
    else if (op == 8'h04) begin d_wel = 1'b0; wel_s[e] = 1'b0; end
    else if (op == 8'h02 && d_wel && wp) begin acc = 1'b1; d_ovf = 1'b0; ovf_s[e] = 1'b0; end
  endtask

  task automatic op_only(input logic [7:0] op);
    int e;
    logic acc;
    send_op(op, 1'b1, acc);
    repeat (2) tick(1'b1, rbit(), 1'b1, rbit(), e);
  endtask

  // hold: 0 none, 1 random hold edges in address, 2 exactly five hold edges mid-address.
  // fmode: 0 FIFO never full, 1 always full, 2 random per word.
  task automatic xfer(input logic [7:0] op, input logic [23:0] a, input logic wp,
                      input int fmode, input int hold, input bit rst_mid);
    int e, cnt;
    logic acc, f;
    logic [23:0] ba;
    logic [15:0] w;
    send_op(op, wp, acc);
    for (int i = 23; i >= 0; i--) begin
      if (hold == 2 && i == 12) repeat (5) tick(1'b0, rbit(), 1'b0, rbit(), e);
      if (hold == 1 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 5)) tick(1'b0, rbit(), 1'b0, rbit(), e);
      tick(1'b0, a[i], 1'b1, rbit(), e);
    end
    cnt = 0;
    ba = a;
    for (int j = 0; j < tx_bytes.size(); j++) begin
      for (int i = 7; i >= 0; i--) begin
        f = rbit();
        if (j % 2 == 1 && i == 0) f = (fmode == 1) ? 1'b1 : (fmode == 2) ? rbit() : 1'b0;
        tick(1'b0, tx_bytes[j][i], 1'b1, f, e);
      end
      if (j % 2 == 1 && acc) begin
        w = {tx_bytes[j-1], tx_bytes[j]};
        if (!f) wen_s[e] = {1'b1, w};
        else begin ovf_s[e] = 1'b1; d_ovf = 1'b1; end
        cnt++;
        if (cnt == WR_BL) begin
          req_s[e+1] = {8'(WR_BL), ba};
          ba = ba + 24'(2 * WR_BL);
          cnt = 0;
        end
      end
    end
    if (rst_mid) begin
      #2 rst_n = 1'b0;
      purge();
      d_wel = 1'b0; d_ovf = 1'b0;
      tick(1'b1, 1'b0, 1'b1, 1'b0, e);
      chk("reset_req", 32'(qspi_wr_req), 32'd0);
      chk("reset_wel", 32'(wel), 32'd0);
      chk("reset_addr", 32'(qspi_wr_addr), 32'd0);
      chk("reset_wen", 32'(fifo_wen), 32'd0);
      tick(1'b1, 1'b0, 1'b1, 1'b0, e);
      rst_n = 1'b1;
      repeat (3) tick(1'b1, 1'b0, 1'b1, 1'b0, e);
    end else begin
      tick(1'b1, rbit(), 1'b1, rbit(), e);
      if (acc) begin
        if (cnt > 0) req_s[e] = {8'(cnt), ba};
        d_wel = 1'b0;
        wel_s[e] = 1'b0;
      end
      repeat (3) tick(1'b1, rbit(), 1'b1, rbit(), e);
    end
  endtask

  task automatic load(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic clr_logs();
    wr_log.delete();
    req_log.delete();
  endtask

  initial begin
    int e;
    logic [7:0]  op;
    logic [23:0] a;
    repeat (3) @(negedge qspi_clk);
    chk("reset_state_wel", 32'(wel), 32'd0);
    chk("reset_state_len", 32'(qspi_wr_len), 32'd0);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 1'b0, e);

    // basic page program
    clr_logs();
    op_only(8'h06);
    tx_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    xfer(8'h02, 24'h001000, 1'b1, 0, 0, 1'b0);
    chk("t1_nwr", 32'(wr_log.size()), 32'd2);
    chk("t1_w0", 32'(wr_log[0]), 32'h0000A1B2);
    chk("t1_w1", 32'(wr_log[1]), 32'h0000C3D4);
    chk("t1_nreq", 32'(req_log.size()), 32'd1);
    chk("t1_req", req_log[0], {8'd2, 24'h001000});
    chk("t1_wel", 32'(wel), 32'd0);

    // program without WREN, then with WREN but write-protected
    clr_logs();
    load(4);
    xfer(8'h02, 24'h000000, 1'b1, 0, 0, 1'b0);
    chk("t2_nwr", 32'(wr_log.size()), 32'd0);
    chk("t2_nreq", 32'(req_log.size()), 32'd0);
    chk("t2_wel", 32'(wel), 32'd0);
    op_only(8'h06);
    load(4);
    xfer(8'h02, 24'h000000, 1'b0, 0, 0, 1'b0);
    chk("t2b_nwr", 32'(wr_log.size()), 32'd0);
    chk("t2b_nreq", 32'(req_log.size()), 32'd0);
    chk("t2b_wel", 32'(wel), 32'd1);

    // partial trailing burst and discarded odd byte
    clr_logs();
    op_only(8'h06);
    load(7);
    xfer(8'h02, 24'h001000, 1'b1, 0, 0, 1'b0);
    chk("t3_nwr", 32'(wr_log.size()), 32'd3);
    chk("t3_nreq", 32'(req_log.size()), 32'd2);
    chk("t3_req0", req_log[0], {8'd2, 24'h001000});
    chk("t3_req1", req_log[1], {8'd1, 24'h001004});

    // address wrap
    clr_logs();
    op_only(8'h06);
    load(8);
    xfer(8'h02, 24'hFFFFFC, 1'b1, 0, 0, 1'b0);
    chk("t4_req0", req_log[0], {8'd2, 24'hFFFFFC});
    chk("t4_req1", req_log[1], {8'd2, 24'h000000});

    // FIFO full: words dropped, overflow sticky until next accepted program
    clr_logs();
    op_only(8'h06);
    load(4);
    xfer(8'h02, 24'h000200, 1'b1, 1, 0, 1'b0);
    chk("t5_nwr", 32'(wr_log.size()), 32'd0);
    chk("t5_ovf", 32'(ovf), 32'd1);
    chk("t5_req", req_log[0], {8'd2, 24'h000200});
    op_only(8'h06);
    load(0);
    xfer(8'h02, 24'h000000, 1'b1, 0, 0, 1'b0);
    chk("t5_ovf_clr", 32'(ovf), 32'd0);

    // hold mid-address
    clr_logs();
    op_only(8'h06);
    load(2);
    xfer(8'h02, 24'h123456, 1'b1, 0, 2, 1'b0);
    chk("t6_req", req_log[0], {8'd1, 24'h123456});

    // reset mid-data
    clr_logs();
    op_only(8'h06);
    load(3);
    xfer(8'h02, 24'h004000, 1'b1, 0, 0, 1'b1);
    chk("t7_nreq", 32'(req_log.size()), 32'd0);
    chk("t7_wel", 32'(wel), 32'd0);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) op_only(8'h06);
      else if (r == 2) op_only(8'h04);
      else begin
        op = (r == 3) ? 8'($urandom_range(0, 255)) : 8'h02;
        a = ($urandom_range(0, 3) == 0) ? (24'hFFFFF0 | 24'($urandom_range(0, 15)))
                                        : 24'($urandom);
        if (op == 8'h02 && $urandom_range(0, 9) < 6) op_only(8'h06);
        load($urandom_range(0, 9));
        xfer(op, a, ($urandom_range(0, 7) != 0), $urandom_range(0, 2), $urandom_range(0, 1), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
